// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the default bus timeout.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int DEFAULT_TIMEOUT = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian byte-lane steering: byte enables and store-data replication on the
// way out, lane extraction and sign/zero extension on the way back.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be    = 4'b0000;
      o_wdata = 32'h0;
      o_rdata = 32'h0;
      w_byte  = 8'h0;
      w_half  = 16'h0;

      // Lowest byte address lives in bits 31:24.
      case (i_offset)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
      w_half = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b1000 >> i_offset;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_be    = i_offset[1] ? 4'b0011 : 4'b1100;
            o_wdata = {2{i_wdata[15:0]}};
            o_rdata = {{16{i_signed & w_half[15]}}, w_half};
         end
         SZ_WORD: begin
            o_be    = 4'b1111;
            o_wdata = i_wdata;
            o_rdata = i_rdata;
         end
         default: begin
            o_be    = 4'b0000;
            o_wdata = 32'h0;
            o_rdata = 32'h0;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: single-outstanding request/ack access to data
// memory with big-endian lane alignment, misalignment and bus-timeout errors.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_load,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic        resp_we,
   output logic [4:0]  resp_rd,
   output logic [31:0] resp_data,
   output logic        err_misalign,
   output logic        err_bus,
   output logic        stall
);

   lsu_state_e       r_state;
   logic [1:0]       r_size;
   logic [1:0]       r_offset;
   logic             r_signed;
   logic             r_load;
   logic [4:0]       r_rd;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]  w_size;
   logic [1:0]  w_offset;
   logic        w_signed;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_rdata;
   logic        w_accept;
   logic        w_misalign;
   logic        w_illegal;

   // Aligner sees the live request while idle and the latched one while waiting.
   assign w_size   = (r_state == ST_IDLE) ? req_size        : r_size;
   assign w_offset = (r_state == ST_IDLE) ? req_addr[1:0]   : r_offset;
   assign w_signed = (r_state == ST_IDLE) ? req_signed      : r_signed;

   assign w_accept   = req_valid & (req_load | req_store);
   assign w_misalign = ((req_size == SZ_HALF) & req_addr[0]) |
                       ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
   assign w_illegal  = (req_size == SZ_RSVD) | (req_load & req_store);

   assign req_ready = (r_state == ST_IDLE);
   assign stall     = ~req_ready;

   lsu_lane_align u_align (
      .i_size   (w_size),
      .i_offset (w_offset),
      .i_signed (w_signed),
      .i_wdata  (req_wdata),
      .i_rdata  (mem_rdata),
      .o_be     (w_be),
      .o_wdata  (w_wdata),
      .o_rdata  (w_rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_IDLE;
         r_size       <= 2'b00;
         r_offset     <= 2'b00;
         r_signed     <= 1'b0;
         r_load       <= 1'b0;
         r_rd         <= 5'd0;
         r_cnt        <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'h0;
         mem_be       <= 4'b0000;
         mem_wdata    <= 32'h0;
         resp_valid   <= 1'b0;
         resp_we      <= 1'b0;
         resp_rd      <= 5'd0;
         resp_data    <= 32'h0;
         err_misalign <= 1'b0;
         err_bus      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_size   <= req_size;
                  r_offset <= req_addr[1:0];
                  r_signed <= req_signed;
                  r_load   <= req_load;
                  r_rd     <= req_rd;
                  r_cnt    <= '0;
                  if (w_misalign || w_illegal) begin
                     r_state      <= ST_RESP;
                     resp_valid   <= 1'b1;
                     resp_we      <= 1'b0;
                     resp_rd      <= req_rd;
                     resp_data    <= 32'h0;
                     err_misalign <= w_misalign;
                     err_bus      <= w_illegal;
                  end else begin
                     r_state   <= ST_WAIT;
                     mem_req   <= 1'b1;
                     mem_we    <= req_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_be    <= w_be;
                     mem_wdata <= req_store ? w_wdata : 32'h0;
                  end
               end
            end

            ST_WAIT: begin
               // An ack in the final timeout cycle still completes normally.
               if (mem_ack || (r_cnt == CNT_W'(TIMEOUT - 1))) begin
                  r_state    <= ST_RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_addr   <= 32'h0;
                  mem_be     <= 4'b0000;
                  mem_wdata  <= 32'h0;
                  resp_valid <= 1'b1;
                  resp_rd    <= r_rd;
                  err_bus    <= ~mem_ack;
                  resp_we    <= mem_ack & r_load & (r_rd != 5'd0);
                  resp_data  <= (mem_ack & r_load) ? w_rdata : 32'h0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_RESP: begin
               r_state      <= ST_IDLE;
               resp_valid   <= 1'b0;
               resp_we      <= 1'b0;
               resp_rd      <= 5'd0;
               resp_data    <= 32'h0;
               err_misalign <= 1'b0;
               err_bus      <= 1'b0;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes expected memory requests
// and responses into queues; negedge monitors pop and compare.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_load = 1'b0;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [4:0]  req_rd = 5'd0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        resp_valid;
   logic        resp_we;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic        err_misalign;
   logic        err_bus;
   logic        stall;

   load_store_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_load(req_load), .req_store(req_store), .req_size(req_size),
      .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_rd(req_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd),
      .resp_data(resp_data), .err_misalign(err_misalign), .err_bus(err_bus),
      .stall(stall)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int n_cmp = 0;
   int n_bad = 0;
   int n_resp = 0;
   int hi_len = 0;
   int last_len = 0;
   logic mem_d = 1'b0;
   logic [68:0] mem_hold = '0;
   logic [68:0] exp_mem[$];
   logic [39:0] exp_resp[$];

   // memory responder controls: ack after ack_lat cycles of mem_req, never if <= 0
   int ack_lat = 0;
   int wait_cnt = 0;
   logic [31:0] mem_word = 32'h0;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [39:0] resp_pack(input logic we, input logic [4:0] rd,
                                             input logic [31:0] d, input logic mis,
                                             input logic bus);
      return {we, rd, d, mis, bus};
   endfunction

   // ---------------- memory responder ----------------
   always @(negedge clk) begin
      if (mem_req) begin
         wait_cnt = wait_cnt + 1;
         mem_ack  = (ack_lat > 0) && (wait_cnt == ack_lat);
         mem_rdata = mem_ack ? mem_word : 32'hA5A5A5A5;
      end else begin
         wait_cnt  = 0;
         mem_ack   = 1'b0;
         mem_rdata = 32'h0;
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [68:0] m_act;
      if (!reset) begin
         mem_d  = 1'b0;
         hi_len = 0;
      end else begin
         m_act = {mem_we, mem_addr, mem_be, (mem_we ? mem_wdata : 32'h0)};
         if (mem_req) begin
            if (!mem_d) begin
               if (exp_mem.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL unexpected_mem_req: got %h expected none", m_act);
               end else begin
                  chk("mem_request", 80'(m_act), 80'(exp_mem.pop_front()));
               end
               mem_hold = m_act;
               hi_len   = 1;
            end else begin
               hi_len = hi_len + 1;
               chk("mem_hold_stable", 80'(m_act), 80'(mem_hold));
            end
         end else if (mem_d) begin
            last_len = hi_len;
         end
         mem_d = mem_req;

         if (resp_valid) begin
            n_resp++;
            if (exp_resp.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_resp: got %h expected none",
                        {resp_we, resp_rd, resp_data, err_misalign, err_bus});
            end else begin
               chk("resp", 80'({resp_we, resp_rd, resp_data, err_misalign, err_bus}),
                   80'(exp_resp.pop_front()));
            end
         end else begin
            chk("resp_idle_zero", 80'({resp_we, resp_rd, resp_data, err_misalign, err_bus}), 80'(0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_ready();
      int g = 0;
      @(negedge clk);
      while (!req_ready && g < 64) begin
         @(negedge clk);
         g++;
      end
      if (g == 64) chk("wait_ready_timeout", 80'(req_ready), 80'(1));
   endtask

   task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] rd, input int lat, input logic [31:0] rw,
                        input logic mv, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic rv, input logic [39:0] er);
      wait_ready();
      ack_lat  = lat;
      mem_word = rw;
      if (mv) exp_mem.push_back({st, addr[31:2], 2'b00, ebe, (st ? ewd : 32'h0)});
      if (rv) exp_resp.push_back(er);
      req_valid  = 1'b1;
      req_load   = ld;
      req_store  = st;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      req_rd     = rd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_load  = 1'b0;
      req_store = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while ((exp_resp.size() != 0 || exp_mem.size() != 0 || !req_ready) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g == 100) chk("wait_done_timeout", 80'(exp_resp.size()), 80'(0));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int resp_snap;

      repeat (3) @(negedge clk);
      chk("reset_ready_stall", 80'({req_ready, stall}), 80'(2'b10));
      chk("reset_mem", 80'({mem_req, mem_we, mem_addr, mem_be, mem_wdata}), 80'(0));
      chk("reset_resp", 80'({resp_valid, resp_we, resp_rd, resp_data, err_misalign, err_bus}), 80'(0));
      reset = 1'b1;

      // word load with one-cycle ack, plus latency check
      issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF,
            1, 4'b1111, 32'h0, 1, resp_pack(1, 5'd5, 32'hDEADBEEF, 0, 0));
      @(negedge clk);
      chk("lat_wait_cycle", 80'({resp_valid, mem_req, stall, req_ready}), 80'(4'b0110));
      @(negedge clk);
      chk("lat_resp_cycle", 80'({resp_valid, mem_req}), 80'(2'b10));

      // byte loads, signed and unsigned
      issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd7, 1, 32'h112233F0,
            1, 4'b0001, 32'h0, 1, resp_pack(1, 5'd7, 32'hFFFFFFF0, 0, 0));
      issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd7, 2, 32'h112233F0,
            1, 4'b0001, 32'h0, 1, resp_pack(1, 5'd7, 32'h000000F0, 0, 0));
      issue(1, 0, 2'b00, 1, 32'h701, 32'h0, 5'd12, 1, 32'h00800000,
            1, 4'b0100, 32'h0, 1, resp_pack(1, 5'd12, 32'hFFFFFF80, 0, 0));

      // stores: half, byte, word
      issue(0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 5'd3, 1, 32'h0,
            1, 4'b0011, 32'hABCDABCD, 1, resp_pack(0, 5'd3, 32'h0, 0, 0));
      issue(0, 1, 2'b00, 0, 32'h301, 32'h12345678, 5'd0, 2, 32'h0,
            1, 4'b0100, 32'h78787878, 1, resp_pack(0, 5'd0, 32'h0, 0, 0));
      issue(0, 1, 2'b10, 0, 32'h800, 32'h01020304, 5'd1, 1, 32'h0,
            1, 4'b1111, 32'h01020304, 1, resp_pack(0, 5'd1, 32'h0, 0, 0));

      // half loads at both offsets
      issue(1, 0, 2'b01, 1, 32'h402, 32'h0, 5'd9, 3, 32'h12348001,
            1, 4'b0011, 32'h0, 1, resp_pack(1, 5'd9, 32'hFFFF8001, 0, 0));
      issue(1, 0, 2'b01, 0, 32'h400, 32'h0, 5'd11, 1, 32'h80017FFF,
            1, 4'b1100, 32'h0, 1, resp_pack(1, 5'd11, 32'h00008001, 0, 0));

      // load to r0: data returned, no register write
      issue(1, 0, 2'b10, 0, 32'h500, 32'h0, 5'd0, 1, 32'h55AA55AA,
            1, 4'b1111, 32'h0, 1, resp_pack(0, 5'd0, 32'h55AA55AA, 0, 0));

      // misaligned word load: response one cycle after accept, no memory access
      issue(1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd4, 0, 32'h0,
            0, 4'b0000, 32'h0, 1, resp_pack(0, 5'd4, 32'h0, 1, 0));
      @(negedge clk);
      chk("misalign_lat", 80'({resp_valid, mem_req}), 80'(2'b10));
      issue(1, 0, 2'b01, 0, 32'h203, 32'h0, 5'd10, 0, 32'h0,
            0, 4'b0000, 32'h0, 1, resp_pack(0, 5'd10, 32'h0, 1, 0));

      // illegal requests: reserved size, load+store together
      issue(1, 0, 2'b11, 0, 32'h100, 32'h0, 5'd13, 0, 32'h0,
            0, 4'b0000, 32'h0, 1, resp_pack(0, 5'd13, 32'h0, 0, 1));
      issue(1, 1, 2'b10, 0, 32'h100, 32'h0, 5'd14, 0, 32'h0,
            0, 4'b0000, 32'h0, 1, resp_pack(0, 5'd14, 32'h0, 0, 1));

      // req_valid with neither load nor store is ignored
      wait_done();
      resp_snap = n_resp;
      @(negedge clk);
      req_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("ignored_ready", 80'({req_ready, mem_req}), 80'(2'b10));
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("ignored_no_resp", 80'(n_resp), 80'(resp_snap));

      // timeout with no ack
      last_len = 0;
      issue(1, 0, 2'b10, 0, 32'h600, 32'h0, 5'd6, 0, 32'h0,
            1, 4'b1111, 32'h0, 1, resp_pack(0, 5'd6, 32'h0, 0, 1));
      wait_done();
      chk("timeout_req_len", 80'(last_len), 80'(16));

      // ack in the final timeout cycle completes normally
      last_len = 0;
      issue(1, 0, 2'b10, 0, 32'h604, 32'h0, 5'd8, 16, 32'hCAFEF00D,
            1, 4'b1111, 32'h0, 1, resp_pack(1, 5'd8, 32'hCAFEF00D, 0, 0));
      wait_done();
      chk("late_ack_req_len", 80'(last_len), 80'(16));

      // reset asserted mid-wait: mem_req drops at once, no response
      resp_snap = n_resp;
      issue(1, 0, 2'b10, 0, 32'h900, 32'h0, 5'd2, 0, 32'h0,
            1, 4'b1111, 32'h0, 0, 40'h0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_mem_req", 80'({mem_req, req_ready, resp_valid}), 80'(3'b010));
      @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk("reset_no_resp", 80'(n_resp), 80'(resp_snap));
      issue(1, 0, 2'b10, 0, 32'h904, 32'h0, 5'd31, 2, 32'h0F0F0F0F,
            1, 4'b1111, 32'h0, 1, resp_pack(1, 5'd31, 32'h0F0F0F0F, 0, 0));
      wait_done();

      repeat (3) @(negedge clk);
      chk("queues_drained", 80'({exp_mem.size(), exp_resp.size()}), 80'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage load/store unit that sits directly downstream of the EX/MEM pipeline register. It takes one effective address plus store data and control per request, and performs sized, big-endian (SPARC) byte-lane alignment. It runs a single-outstanding request/ack handshake to data memory and returns aligned, extended load data with a destination register to the MEM/WB stage. It stalls the pipeline while busy and reports misalignment and bus-timeout errors.

Parameters:
TIMEOUT, 16, cycles in WAIT without mem_ack before bus error is flagged (>=2)
CNT_W, 5, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  EX/MEM presents an access this cycle
req_ready  out  1  unit can accept a request (high only in IDLE)
req_load  in  1  access is a load
req_store  in  1  access is a store
req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
req_signed  in  1  sign-extend load result (0 = zero-extend)
req_addr  in  32  effective byte address
req_wdata  in  32  store data, right-justified
req_rd  in  5  load destination register
mem_req  out  1  memory access request, held until ack or timeout
mem_we  out  1  1 = write
mem_addr  out  32  word address {req_addr[31:2],2'b00}
mem_be  out  4  byte enables; be[3] = bits 31:24 (lowest byte address)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completed the access (sampled only in WAIT)
mem_rdata  in  32  read word, valid with mem_ack
resp_valid  out  1  one-cycle completion pulse
resp_we  out  1  register write required (load, no error, rd != 0)
resp_rd  out  5  destination register
resp_data  out  32  aligned, extended load data (0 for stores/errors)
err_misalign  out  1  valid with resp_valid: alignment fault
err_bus  out  1  valid with resp_valid: timeout or illegal request
stall  out  1  ~req_ready; freezes upstream pipe registers

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (reset=0): state=IDLE, counter=0. All outputs 0 except req_ready=1. Asserting reset mid-access drops mem_req immediately, and no response is produced.
- States:
  - IDLE: req_ready=1. A request is accepted when req_valid=1 and (req_load or req_store). req_valid with neither bit set is ignored.
  - On acceptance, latch all req_* fields.
  - Fault check (no memory access; go to RESP): half with addr[0]=1, or word with addr[1:0]!=0 -> err_misalign. size=11, or load and store both set -> err_bus.
  - Otherwise go to WAIT with mem_req=1.
- WAIT:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable. Counter increments each cycle.
  - mem_ack=1: capture the extracted load data and go to RESP.
  - Counter==TIMEOUT-1 with no ack: err_bus=1, mem_req drops, go to RESP. An ack arriving in that same cycle wins over the timeout.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Error flags and resp_* are registered and are 0 outside RESP.
- Latency: accept edge N; ack seen at edge N+1 -> resp_valid high during cycle N+1..N+2. Back-to-back throughput is one access per 3 cycles minimum.
- Store lanes (big-endian):
  - byte offset k -> be = 4'b1000>>k, wdata = {4{d[7:0]}}
  - half offset 0 -> be=1100, offset 2 -> be=0011, wdata = {2{d[15:0]}}
  - word -> be=1111
- Load lanes use the same mapping, with be = lanes read.
  - byte k selects rdata[31-8k -: 8]; half offset 0 selects [31:16], offset 2 selects [15:0].
  - Extend to 32 bits per req_signed.
- resp_we = load & ~err_misalign & ~err_bus & (rd!=0). Stores give resp_valid with resp_we=0.
- stall = ~req_ready, combinational from state.

Decomposition:
- Shared package lsu_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), state enum (IDLE/WAIT/RESP), default TIMEOUT.
- One combinational sub-module lsu_lane_align: produces be/wdata replication on the store path and extract/extend on the load path. FSM, counter and latches stay in load_store_unit.

Test Plan:
- Word load, addr=0x100, mem_ack 1 cycle after mem_req with rdata=0xDEADBEEF, rd=5 -> mem_be=1111, resp_data=0xDEADBEEF, resp_we=1, resp_rd=5.
- Signed byte load, addr=0x103, rdata=0x112233F0 -> be=0001, resp_data=0xFFFFFFF0. Repeat unsigned -> 0x000000F0.
- Half store, addr=0x202, wdata=0x0000ABCD -> mem_addr=0x200, be=0011, mem_wdata=0xABCDABCD, mem_we=1, resp_we=0.
- Misaligned word load, addr=0x101 -> no mem_req, resp_valid one cycle later with err_misalign=1, resp_we=0.
- No ack, TIMEOUT=16 -> mem_req high 16 cycles, then err_bus=1. Ack on cycle 16 instead -> normal completion, err_bus=0.
- reset low during WAIT -> mem_req=0 asynchronously, no resp_valid. After release, a new load completes normally.
